md4_iter_core: RTL and testbench

Iterative MD4 compression engine. One shared round-step datapath (F/G/H boolean function, 32-bit adder, variable left-rotate) is time-multiplexed over all 48 MD4 steps under a control FSM. This replaces the fully unrolled three-stage combinational chain with a compact sequential core. It sits between the message-padding/block-feeder logic and the digest consumer, and keeps the chaining value internally for multi-block messages.

---
 rtl/md4_iter_core.sv | 173 +++++++++++++++++
 tb/tb_md4_iter_core.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/md4_iter_core.sv
// rtl/md4_iter_core.sv - iterative MD4 compression core, one round step per clock
module md4_iter_core (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         init,
  input  logic [511:0] block,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [127:0] digest
);

  localparam logic [31:0] IV_A = 32'h67452301;
  localparam logic [31:0] IV_B = 32'hefcdab89;
  localparam logic [31:0] IV_C = 32'h98badcfe;
  localparam logic [31:0] IV_D = 32'h10325476;
  localparam logic [127:0] IV_DIGEST = {IV_D, IV_C, IV_B, IV_A};

  localparam logic [31:0] K_R1 = 32'h00000000;
  localparam logic [31:0] K_R2 = 32'h5a827999;
  localparam logic [31:0] K_R3 = 32'h6ed9eba1;

  localparam logic [5:0] LAST_STEP = 6'd47;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FINISH
  } state_t;

  state_t        state;
  logic [5:0]    step;
  logic [511:0]  msg;
  // Working registers; a is always the target of the current step and the
  // set rotates by one position per step, so after 48 steps (a multiple of
  // four) every register is back in its original slot.
  logic [31:0]   wa, wb, wc, wd;
  // Seed captured at accept, added back in during FINISH.
  logic [127:0]  seed;

  logic [1:0]    round;
  logic [3:0]    pos;
  logic [31:0]   fn_val;
  logic [31:0]   k_const;
  logic [3:0]    x_idx;
  logic [4:0]    shamt;
  logic [31:0]   x_word;
  logic [31:0]   step_sum;
  logic [31:0]   step_rot;

  assign round = step[5:4];
  assign pos   = step[3:0];

  // Per-step boolean function, round constant, message word index and shift.
  always_comb begin
    fn_val  = 32'd0;
    k_const = 32'd0;
    x_idx   = 4'd0;
    shamt   = 5'd3;
    case (round)
      2'd0: begin
        fn_val  = (wb & wc) | (~wb & wd);
        k_const = K_R1;
        x_idx   = pos;
        case (pos[1:0])
          2'd0:    shamt = 5'd3;
          2'd1:    shamt = 5'd7;
          2'd2:    shamt = 5'd11;
          default: shamt = 5'd19;
        endcase
      end
      2'd1: begin
        fn_val  = (wb & wc) | (wb & wd) | (wc & wd);
        k_const = K_R2;
        x_idx   = {pos[1:0], pos[3:2]};
        case (pos[1:0])
          2'd0:    shamt = 5'd3;
          2'd1:    shamt = 5'd5;
          2'd2:    shamt = 5'd9;
          default: shamt = 5'd13;
        endcase
      end
      default: begin
        fn_val  = wb ^ wc ^ wd;
        k_const = K_R3;
        x_idx   = {pos[0], pos[1], pos[2], pos[3]};
        case (pos[1:0])
          2'd0:    shamt = 5'd3;
          2'd1:    shamt = 5'd9;
          2'd2:    shamt = 5'd11;
          default: shamt = 5'd15;
        endcase
      end
    endcase
  end

  // Shared adder and rotator; shamt is never zero, so (0 - shamt) mod 32
  // is the complementary right-shift amount.
  always_comb begin
    x_word   = msg[{x_idx, 5'd0} +: 32];
    step_sum = wa + fn_val + x_word + k_const;
    step_rot = (step_sum << shamt) | (step_sum >> (5'd0 - shamt));
  end

  // Control FSM, working-register rotation and chaining-value commit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      step   <= 6'd0;
      msg    <= '0;
      wa     <= 32'd0;
      wb     <= 32'd0;
      wc     <= 32'd0;
      wd     <= 32'd0;
      seed   <= '0;
      digest <= IV_DIGEST;
      ready  <= 1'b1;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            msg   <= block;
            step  <= 6'd0;
            ready <= 1'b0;
            busy  <= 1'b1;
            state <= ST_RUN;
            if (init) begin
              wa   <= IV_A;
              wb   <= IV_B;
              wc   <= IV_C;
              wd   <= IV_D;
              seed <= IV_DIGEST;
            end else begin
              wa   <= digest[31:0];
              wb   <= digest[63:32];
              wc   <= digest[95:64];
              wd   <= digest[127:96];
              seed <= digest;
            end
          end
        end
        ST_RUN: begin
          wa   <= wd;
          wb   <= step_rot;
          wc   <= wb;
          wd   <= wc;
          step <= step + 6'd1;
          if (step == LAST_STEP) begin
            state <= ST_FINISH;
          end
        end
        ST_FINISH: begin
          digest <= {wd + seed[127:96], wc + seed[95:64],
                     wb + seed[63:32],  wa + seed[31:0]};
          done   <= 1'b1;
          ready  <= 1'b1;
          busy   <= 1'b0;
          state  <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_md4_iter_core.sv
// tb/tb_md4_iter_core.sv - scoreboard bench for md4_iter_core with known MD4 vectors
module tb_md4_iter_core;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         init;
  logic [511:0] block;
  logic         ready;
  logic         busy;
  logic         done;
  logic [127:0] digest;

  md4_iter_core dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .init   (init),
    .block  (block),
    .ready  (ready),
    .busy   (busy),
    .done   (done),
    .digest (digest)
  );

  localparam logic [127:0] IV_DIG    = 128'h10325476_98badcfe_efcdab89_67452301;
  localparam logic [127:0] EMPTY_DIG = 128'hc089c0e0_d7593cb7_31e96ad1_e0cfd631;
  localparam logic [127:0] ABC_DIG   = 128'h9d72a67a_e80ac15f_52d821af_7a0148a4;
  // MD4 of the 80-digit string "1234567890" x 8
  localparam logic [127:0] DIG80_DIG = 128'h3605cc4f_167b3e9c_19f2389c_dc4d3be3;

  typedef struct {
    logic [127:0] dig;
    logic         chk_dig;
    int           acc;
  } exp_t;

  exp_t sb[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int n_done   = 0;

  logic [511:0] blk_empty;
  logic [511:0] blk_abc;
  logic [511:0] blk_d1;
  logic [511:0] blk_d2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [511:0] digit_block(input int off, input int nbytes);
    logic [511:0] b;
    b = '0;
    for (int i = 0; i < nbytes; i++) begin
      b[8*i +: 8] = 8'(48 + ((off + i + 1) % 10));
    end
    return b;
  endfunction

  // Monitor: every done pulse pops one expectation and checks digest, latency, status.
  always @(negedge clk) begin
    if (rst_n && done) begin
      exp_t e;
      n_done++;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 required=0 at cycle %0d", cyc);
      end else begin
        e = sb.pop_front();
        if (e.chk_dig) chk("digest", digest, e.dig);
        chk("done_latency", 128'(cyc - e.acc), 128'(49));
        chk("ready_busy_at_done", {126'd0, ready, busy}, 128'b10);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Issue start at a negedge where ready is seen; returns just after the accept edge.
  task automatic issue(input logic [511:0] blk, input logic ini, output int acc);
    int n;
    n = 0;
    @(negedge clk);
    while (!ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      checks++;
      failures++;
      $display("FAIL wait_ready actual=timeout required=ready");
    end
    start = 1'b1;
    init  = ini;
    block = blk;
    @(posedge clk);
    #1;
    acc   = cyc;
    start = 1'b0;
    init  = 1'b0;
    block = '0;
    chk("ready_busy_after_accept", {126'd0, ready, busy}, 128'b01);
  endtask

  task automatic run_block(input logic [511:0] blk, input logic ini, input logic [127:0] exp_dig);
    int acc;
    issue(blk, ini, acc);
    sb.push_back('{dig: exp_dig, chk_dig: 1'b1, acc: acc});
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain actual=%0d_pending required=0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    int acc1;
    int acc2;
    int d0;

    rst_n = 1'b0;
    start = 1'b0;
    init  = 1'b0;
    block = '0;

    blk_empty = '0;
    blk_empty[31:0] = 32'h00000080;
    blk_abc = '0;
    blk_abc[31:0]    = 32'h80636261;
    blk_abc[479:448] = 32'h00000018;
    blk_d1 = digit_block(0, 64);
    blk_d2 = digit_block(64, 16);
    blk_d2[135:128] = 8'h80;
    blk_d2[479:448] = 32'h00000280;

    // Reset state
    do_reset();
    @(negedge clk);
    chk("reset_digest", digest, IV_DIG);
    chk("reset_ready_busy_done", {125'd0, ready, busy, done}, 128'b100);

    // Empty message and "abc"
    run_block(blk_empty, 1'b1, EMPTY_DIG);
    drain();
    run_block(blk_abc, 1'b1, ABC_DIG);
    drain();
    chk("digest_held_idle", digest, ABC_DIG);

    // Two-block message, start held high through the first done
    d0 = n_done;
    @(negedge clk);
    start = 1'b1;
    init  = 1'b1;
    block = blk_d1;
    @(posedge clk);
    #1;
    acc1  = cyc;
    sb.push_back('{dig: '0, chk_dig: 1'b0, acc: acc1});
    init  = 1'b0;
    block = blk_d2;
    repeat (49) @(posedge clk);
    #1;
    chk("done_first_block", {127'd0, done}, 128'd1);
    @(posedge clk);
    #1;
    acc2  = cyc;
    start = 1'b0;
    block = '0;
    chk("ready_busy_second_accept", {126'd0, ready, busy}, 128'b01);
    sb.push_back('{dig: DIG80_DIG, chk_dig: 1'b1, acc: acc2});
    drain();
    repeat (5) @(negedge clk);
    chk("two_block_done_count", 128'(n_done - d0), 128'd2);

    // Stray start at step 20 is ignored
    issue(blk_abc, 1'b1, acc1);
    sb.push_back('{dig: ABC_DIG, chk_dig: 1'b1, acc: acc1});
    repeat (20) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    init  = 1'b1;
    block = blk_empty;
    @(posedge clk);
    #1;
    start = 1'b0;
    block = '0;
    chk("busy_after_stray_start", {126'd0, ready, busy}, 128'b01);
    drain();

    // Reset at step 30 aborts with no done
    d0 = n_done;
    issue(blk_empty, 1'b1, acc1);
    repeat (30) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_digest_iv", digest, IV_DIG);
    chk("abort_ready_busy_done", {125'd0, ready, busy, done}, 128'b100);
    repeat (60) @(negedge clk);
    chk("abort_no_done", 128'(n_done - d0), 128'd0);
    run_block(blk_abc, 1'b1, ABC_DIG);
    drain();

    // init=0 right after reset seeds from the IV
    do_reset();
    run_block(blk_abc, 1'b0, ABC_DIG);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time limit in case a wait loop misbehaves
  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
